// File: rtl/value_text_row.sv
// Formats a WIDTH-bit value as a right-aligned ASCII row in binary, hex, unsigned or signed decimal.
// Rows are built into a shadow buffer and committed to the display buffer in a single edge.
module value_text_row #(
   parameter int WIDTH       = 16,
   parameter int COLS        = 16,
   parameter bit AUTO_UPDATE = 1'b1
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic [WIDTH-1:0]         value,
   input  logic [1:0]               mode,
   input  logic                     update,
   input  logic [$clog2(COLS)-1:0]  outputCharIndex,
   output logic [7:0]               outByte,
   output logic                     busy
);
   localparam int DEC_DIGITS = ((WIDTH * 1233) >> 12) + 1;
   localparam int HEX_DIGITS = (WIDTH + 3) / 4;
   localparam int MAX_CNT    = (WIDTH > COLS) ? WIDTH : COLS;
   localparam int CNT_W      = $clog2(MAX_CNT + 1);

   typedef enum logic [1:0] {IDLE, CONV, FORMAT, COMMIT} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    pend_q, pend_d;
   logic [WIDTH-1:0]        last_val_q, last_val_d;
   logic [1:0]              last_mode_q, last_mode_d;
   logic [WIDTH-1:0]        val_q, val_d;
   logic [1:0]              mode_q, mode_d;
   logic [WIDTH-1:0]        sh_q, sh_d;
   logic                    neg_q, neg_d;
   logic [4*DEC_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
   logic [7:0]              shadow_q [COLS];
   logic [7:0]              shadow_d [COLS];
   logic [7:0]              disp_q [COLS];
   logic [7:0]              disp_d [COLS];
   logic [7:0]              out_byte_q, out_byte_d;
   logic [7:0]              row [COLS];
   logic [7:0]              dig_chr [WIDTH];
   logic [4*HEX_DIGITS-1:0] hex_val;
   logic [3:0]              nib;
   logic                    auto_trig, start;
   int                      nd, nd_dec;

   assign busy    = (state_q != IDLE);
   assign outByte = out_byte_q;

   // Character row for the captured value; digit i counts from the right.
   always_comb begin
      hex_val = (4*HEX_DIGITS)'(val_q);
      nib     = 4'd0;
      nd_dec  = 1;
      for (int i = 0; i < DEC_DIGITS; i++)
         if (bcd_q[4*i +: 4] != 4'd0) nd_dec = i + 1;
      for (int i = 0; i < WIDTH; i++) dig_chr[i] = 8'h30;
      case (mode_q)
         2'd0: begin
            nd = WIDTH;
            for (int i = 0; i < WIDTH; i++) dig_chr[i] = {7'h18, val_q[i]};
         end
         2'd1: begin
            nd = HEX_DIGITS;
            for (int i = 0; i < HEX_DIGITS; i++) begin
               nib        = hex_val[4*i +: 4];
               dig_chr[i] = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
            end
         end
         default: begin
            nd = nd_dec;
            for (int i = 0; i < DEC_DIGITS; i++) dig_chr[i] = 8'h30 + {4'h0, bcd_q[4*i +: 4]};
         end
      endcase
      for (int c = 0; c < COLS; c++) begin
         row[c] = 8'h20;
         for (int i = 0; i < WIDTH; i++)
            if (i < nd && (COLS - 1 - c) == i) row[c] = dig_chr[i];
         if (neg_q && (COLS - 1 - c) == nd) row[c] = 8'h2D;
      end
      if (nd + int'(neg_q) > COLS) row[0] = 8'h3C;
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < DEC_DIGITS; d++)
         if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
   end

   // Next-state logic; requests arriving while busy collapse into one pending start.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      last_val_d  = last_val_q;
      last_mode_d = last_mode_q;
      val_d       = val_q;
      mode_d      = mode_q;
      sh_d        = sh_q;
      neg_d       = neg_q;
      bcd_d       = bcd_q;
      shadow_d    = shadow_q;
      disp_d      = disp_q;
      auto_trig   = AUTO_UPDATE && ((value != last_val_q) || (mode != last_mode_q));
      start       = (state_q == IDLE) && (update || pend_q || auto_trig);
      case (state_q)
         IDLE: begin
            if (start) begin
               pend_d      = 1'b0;
               last_val_d  = value;
               last_mode_d = mode;
               val_d       = value;
               mode_d      = mode;
               neg_d       = (mode == 2'd3) && value[WIDTH-1];
               sh_d        = ((mode == 2'd3) && value[WIDTH-1]) ? -value : value;
               bcd_d       = '0;
               cnt_d       = '0;
               state_d     = mode[1] ? CONV : FORMAT;
            end
         end
         CONV: begin
            bcd_d = (bcd_adj << 1) | {{(4*DEC_DIGITS-1){1'b0}}, sh_q[WIDTH-1]};
            sh_d  = sh_q << 1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = FORMAT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FORMAT: begin
            for (int c = 0; c < COLS; c++)
               if (int'(cnt_q) == c) shadow_d[c] = row[c];
            if (cnt_q == CNT_W'(COLS - 1)) begin
               cnt_d   = '0;
               state_d = COMMIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         COMMIT: begin
            disp_d  = shadow_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && (update || auto_trig)) pend_d = 1'b1;
   end

   always_comb begin
      out_byte_d = 8'h20;
      for (int c = 0; c < COLS; c++)
         if (int'(outputCharIndex) == c) out_byte_d = disp_q[c];
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         last_val_q  <= '0;
         last_mode_q <= 2'd0;
         val_q       <= '0;
         mode_q      <= 2'd0;
         sh_q        <= '0;
         neg_q       <= 1'b0;
         bcd_q       <= '0;
         out_byte_q  <= 8'h20;
         for (int c = 0; c < COLS; c++) begin
            shadow_q[c] <= 8'h20;
            disp_q[c]   <= 8'h20;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         last_val_q  <= last_val_d;
         last_mode_q <= last_mode_d;
         val_q       <= val_d;
         mode_q      <= mode_d;
         sh_q        <= sh_d;
         neg_q       <= neg_d;
         bcd_q       <= bcd_d;
         out_byte_q  <= out_byte_d;
         shadow_q    <= shadow_d;
         disp_q      <= disp_d;
      end
   end

endmodule

// File: tb/tb_value_text_row.sv
// Directed bench for value_text_row: a 16-bit manual-update instance and a 20-bit auto-update instance.
module tb_value_text_row;
   typedef struct {
      logic [15:0] value;
      logic [1:0]  mode;
      string       exp_row;
      int          exp_busy;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic [15:0] value;
   logic [1:0]  mode;
   logic        update;
   logic [3:0]  idx;
   logic [7:0]  out_byte;
   logic        busy;
   logic [19:0] val20;
   logic [1:0]  mode20;
   logic [3:0]  idx20;
   logic [7:0]  out20;
   logic        busy20;

   int checks   = 0;
   int failures = 0;

   value_text_row #(.WIDTH(16), .COLS(16), .AUTO_UPDATE(1'b0)) u_dut (
      .clk(clk), .rstN(rstN), .value(value), .mode(mode), .update(update),
      .outputCharIndex(idx), .outByte(out_byte), .busy(busy)
   );

   value_text_row #(.WIDTH(20), .COLS(16), .AUTO_UPDATE(1'b1)) u_w20 (
      .clk(clk), .rstN(rstN), .value(val20), .mode(mode20), .update(1'b0),
      .outputCharIndex(idx20), .outByte(out20), .busy(busy20)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic string padRow(input string s);
      string r = "                ";
      for (int i = 0; i < s.len(); i++) r.putc(16 - s.len() + i, s[i]);
      return r;
   endfunction

   task automatic checkOutput(input string name, input string got, input string exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("[TB] FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
      end
   endtask

   task automatic checkValue(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic readRow(input bit wide, output string row);
      row = "                ";
      for (int c = 0; c < 16; c++) begin
         if (wide) idx20 = 4'(c);
         else      idx = 4'(c);
         step();
         row.putc(c, wide ? out20 : out_byte);
      end
   endtask

   task automatic countBusy(input bit wide, output int cycles);
      cycles = 0;
      while ((wide ? busy20 : busy) && cycles < 200) begin
         cycles++;
         step();
      end
   endtask

   task automatic applyStimulus(input logic [15:0] v, input logic [1:0] m, output int cycles);
      value  = v;
      mode   = m;
      update = 1'b1;
      step();
      update = 1'b0;
      countBusy(1'b0, cycles);
   endtask

   vec_t  vecs [11];
   string row;
   int    cycles;

   initial begin
      vecs[0]  = '{16'd12345, 2'd2, padRow("12345"), 33};
      vecs[1]  = '{16'd0,     2'd2, padRow("0"), 33};
      vecs[2]  = '{16'h8000,  2'd3, padRow("-32768"), 33};
      vecs[3]  = '{16'hFFFF,  2'd3, padRow("-1"), 33};
      vecs[4]  = '{16'hBEEF,  2'd1, padRow("BEEF"), 17};
      vecs[5]  = '{16'hA5A5,  2'd0, "1010010110100101", 17};
      vecs[6]  = '{16'hFFFF,  2'd2, padRow("65535"), 33};
      vecs[7]  = '{16'h7FFF,  2'd3, padRow("32767"), 33};
      vecs[8]  = '{16'h0012,  2'd1, padRow("0012"), 17};
      vecs[9]  = '{16'h8000,  2'd2, padRow("32768"), 33};
      vecs[10] = '{16'h0005,  2'd3, padRow("5"), 33};

      rstN = 1'b0; value = '0; mode = 2'd0; update = 1'b0; idx = '0;
      val20 = '0; mode20 = 2'd0; idx20 = '0;
      #12;
      checkValue("reset_busy_low", int'(busy), 0);
      checkValue("reset_outbyte", int'(out_byte), 32'h20);
      @(negedge clk);
      rstN = 1'b1;
      step();
      step();
      readRow(1'b0, row);
      checkOutput("reset_row", row, padRow(""));
      checkValue("reset_busy_idle", int'(busy), 0);
      checkValue("w20_no_auto_start", int'(busy20), 0);

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].value, vecs[i].mode, cycles);
         checkValue($sformatf("busy_len_%0d", i), cycles, vecs[i].exp_busy);
         readRow(1'b0, row);
         checkOutput($sformatf("row_%0d", i), row, vecs[i].exp_row);
      end

      // Display holds the old row until the commit edge; the read on that edge is still old.
      applyStimulus(16'd12345, 2'd2, cycles);
      idx    = 4'd15;
      value  = 16'hBEEF;
      mode   = 2'd1;
      update = 1'b1;
      step();
      update = 1'b0;
      repeat (16) step();
      checkValue("hold_busy_e16", int'(busy), 1);
      checkValue("hold_old_e16", int'(out_byte), 32'h35);
      step();
      checkValue("hold_busy_e17", int'(busy), 0);
      checkValue("hold_old_e17", int'(out_byte), 32'h35);
      step();
      checkValue("hold_new_e18", int'(out_byte), 32'h46);

      // Three requests while busy collapse into one extra conversion at COMMIT+1.
      value  = 16'h00AB;
      mode   = 2'd1;
      update = 1'b1;
      step();
      update = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         update = 1'b1;
         step();
         update = 1'b0;
      end
      value = 16'h1234;
      repeat (11) step();
      checkValue("pend_commit_idle", int'(busy), 0);
      step();
      checkValue("pend_restart", int'(busy), 1);
      countBusy(1'b0, cycles);
      checkValue("pend_busy_len", cycles, 17);
      repeat (4) step();
      checkValue("pend_no_third", int'(busy), 0);
      readRow(1'b0, row);
      checkOutput("pend_row", row, padRow("1234"));

      // Auto-update on the 20-bit instance, overflowing binary row.
      val20  = 20'hFFFFF;
      mode20 = 2'd0;
      step();
      checkValue("w20_auto_busy", int'(busy20), 1);
      countBusy(1'b1, cycles);
      checkValue("w20_busy_len", cycles, 17);
      readRow(1'b1, row);
      checkOutput("w20_overflow_row", row, "<111111111111111");
      checkValue("w20_no_retrigger", int'(busy20), 0);

      // Reset in the middle of a decimal conversion.
      idx    = 4'd12;
      value  = 16'd999;
      mode   = 2'd2;
      update = 1'b1;
      step();
      update = 1'b0;
      repeat (5) step();
      checkValue("pre_reset_busy", int'(busy), 1);
      rstN = 1'b0;
      #1;
      checkValue("midreset_busy", int'(busy), 0);
      checkValue("midreset_outbyte", int'(out_byte), 32'h20);
      step();
      rstN = 1'b1;
      step();
      readRow(1'b0, row);
      checkOutput("midreset_row", row, padRow(""));
      checkValue("midreset_idle", int'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/value_text_row.md
# value_text_row

Parametrised value-to-text row formatter. It converts a WIDTH-bit value into a right-aligned ASCII row of COLS characters in binary, hex, unsigned decimal or signed decimal. The result is held in a double-buffered character store that the text engine reads by column index. It sits between value sources (counters, UART-fed registers) and the text engine's per-row character mux, replacing fixed-width single-format rows.

## Interface
- WIDTH, 16, value width; legal 1..32
- COLS, 16, characters per row; legal 4..32
- AUTO_UPDATE, 1, 1 = start a conversion automatically when value or mode differs from the last captured pair
- clk  input  1  system clock
- rstN  input  1  reset; one clock, reset asynchronous and active-low
- value  input  WIDTH  number to format
- mode  input  2  0 binary, 1 hex, 2 unsigned decimal, 3 signed decimal
- update  input  1  single-cycle conversion request
- outputCharIndex  input  $clog2(COLS)  column to read; 0 is leftmost
- outByte  output  8  ASCII character at the requested column (registered)
- busy  output  1  high while a conversion is in flight

## Operation
- Derived digit counts:
  - DEC_DIGITS = ((WIDTH*1233)>>12)+1
  - HEX_DIGITS = (WIDTH+3)/4
  - BIN_DIGITS = WIDTH
- Start condition in IDLE: update, a pending request, or (AUTO_UPDATE and {value,mode} differs from the last captured pair). value and mode are captured on the start edge.
- FSM states: IDLE, CONV, FORMAT, COMMIT.
  - IDLE -> CONV on start when mode is 2 or 3; IDLE -> FORMAT on start when mode is 0 or 1.
  - CONV: iterative double-dabble, one input bit per cycle, exactly WIDTH cycles, then FORMAT.
  - FORMAT: writes one shadow column per cycle, column 0 first, exactly COLS cycles, then COMMIT.
  - COMMIT: 1 cycle. Display buffer <= shadow buffer in one edge, then IDLE.
- Binary and hex formatting:
  - Full digit count, zero-padded, right-aligned.
  - Hex uses uppercase 0-9 and A-F.
  - Unused columns on the left are 0x20.
- Decimal formatting:
  - Leading-zero suppressed (spaces); value 0 renders as "0".
  - Mode 3 with MSB set: the magnitude is the two's-complement negation in WIDTH bits, treated as unsigned, so the most-negative value is correct. A '-' is placed immediately left of the most significant digit.
  - Mode 2 ignores the sign.
- Overflow: if the required characters (digits plus sign) exceed COLS, column 0 = '<' and columns 1..COLS-1 hold the least significant COLS-1 characters.
- Request collapsing:
  - update (or an auto trigger) while busy sets pending; multiple such requests collapse into one.
  - pending clears on the next start, which uses the value and mode current at that start edge.
- The display buffer changes only at COMMIT, so readers never see a partial row.
- Read path: outByte <= display[outputCharIndex] every cycle. An index >= COLS returns 0x20.

## Timing
- Reset (asynchronous, rstN low):
  - state IDLE; busy 0; pending 0.
  - Every shadow and display column = 0x20; outByte = 0x20.
  - The last-captured pair is cleared to value 0, mode 0.
- Reset mid-conversion aborts the conversion; the display returns to all spaces.
- Start edge E0: busy = 1 after E0.
- Display update latency:
  - Modes 2 and 3: display updates at E0+WIDTH+COLS+1.
  - Modes 0 and 1: display updates at E0+COLS+1.
  - busy falls on the same edge as the display update.
- A pending request starts on the first IDLE edge after COMMIT, i.e. COMMIT+1.
- outByte latency: 1 cycle from outputCharIndex.
- A simultaneous read and COMMIT on the same edge returns the old display content; the new content is visible on the next read.
- After reset release, AUTO_UPDATE starts a conversion only if {value,mode} differs from the cleared pair (0,0).

## Test plan
- Reset and release with value=0, mode=0, AUTO_UPDATE=0 -> every column reads 0x20, busy=0; outByte=0x20 one cycle after each index.
- WIDTH=16, COLS=16, mode 2, value=12345, update pulse -> busy for exactly 33 cycles. Then columns 0..10 are 0x20 and columns 11..15 are "12345"; value=0 gives "0" in column 15.
- Mode 3, value=16'h8000 -> columns 10..15 "-32768". Value=16'hFFFF -> columns 14..15 "-1".
- Mode 1, value=16'hBEEF -> display changes 17 cycles after update; columns 12..15 "BEEF", others 0x20. The display holds the old row until that edge.
- WIDTH=20, mode 0, value=20'hFFFFF -> column 0 '<', columns 1..15 '1'.
- Three update pulses during busy -> exactly one extra conversion, starting at COMMIT+1. Asserting rstN low mid-CONV -> busy=0 immediately and all columns read 0x20.
